dram_stream_port: RTL
=====================

Name: dram_stream_port

Overview:
- DRAM-side endpoint of the DMA streaming interface: the responder that feeds and drains the UB DMA engine's streams.
- Read direction (dir=1): fetches `length` words from DRAM starting at `dram_base_addr` and sources them on `s_out_*`, which connects to the DMA `in_*` port.
- Write direction (dir=0): sinks words from `s_in_*` (connected to the DMA `out_*` port) and writes them to consecutive DRAM addresses.
- Sits between the DMA engine and the external memory request/grant bus.

Parameters:
- ADDR_W, default ADDR_WIDTH: DRAM word-address width.
- DATA_W, default DATA_WIDTH: data word width.
- FIFO_DEPTH, default 4: read-return buffer depth. Must be a power of 2, ≥2.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a transfer; sampled in IDLE only.
- dir  in  1  1: DRAM->stream (read), 0: stream->DRAM (write).
- dram_base_addr  in  ADDR_W  first DRAM word address; latched at start.
- length  in  16  word count; latched at start.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle completion pulse.
- s_out_valid  out  1  read data valid.
- s_out_ready  in  1  downstream (DMA) accepts.
- s_out_data  out  DATA_W  read data word.
- s_in_valid  in  1  write data valid.
- s_in_ready  out  1  port accepts a write word.
- s_in_data  in  DATA_W  write data word.
- mem_req  out  1  DRAM request; held until granted.
- mem_we  out  1  1 = write request.
- mem_addr  out  ADDR_W  request address.
- mem_wdata  out  DATA_W  write data.
- mem_gnt  in  1  request accepted this cycle (mem_req && mem_gnt).
- mem_rvalid  in  1  read return valid, in request order, latency ≥1.
- mem_rdata  in  DATA_W  read return data.

Behaviour:
- Reset: state=IDLE; all counters, FIFO and holding register cleared. Outputs busy, done, s_out_valid, s_in_ready, mem_req and mem_we are 0; mem_addr, mem_wdata and s_out_data are 0.
- States: IDLE, READ, WRITE, DONE.
  - IDLE: on start, latch base and length, clear counters.
    - length==0 -> DONE.
    - Otherwise -> READ if dir=1, WRITE if dir=0.
  - DONE: done=1 for exactly one cycle, then IDLE.
  - start outside IDLE is ignored.
- Counters (16 bit): issued, outstanding, delivered.
- mem_addr = base + issued, truncated to ADDR_W; wraps modulo 2^ADDR_W.
- READ:
  - Issue when issued<length and outstanding+fifo_count < FIFO_DEPTH (credit rule).
  - mem_req=1, mem_we=0; once asserted, mem_req/mem_addr stay stable until mem_gnt.
  - On grant: issued++, outstanding++.
  - mem_rvalid: push mem_rdata into the FIFO, outstanding--. The credit rule guarantees no overflow; a push into a full FIFO is an assertion failure.
  - s_out_valid = FIFO not empty; s_out_data = FIFO head, first-word-fall-through.
  - On s_out_valid&&s_out_ready: pop, delivered++.
  - Grant, return and pop in the same cycle are all legal; counters net correctly.
  - Leave for DONE in the cycle after delivered reaches length.
  - Minimum latency first grant -> s_out_valid: 1 cycle after mem_rvalid.
- WRITE:
  - One-entry holding register.
  - s_in_ready = holding empty && delivered<length, where delivered counts accepted words here.
  - On accept: load s_in_data into holding, delivered++.
  - While holding full: mem_req=1, mem_we=1, mem_wdata=holding, mem_addr=base+issued.
  - On mem_gnt: issued++, holding empties. No same-cycle refill; throughput 1 word per 2 cycles.
  - When issued==length and holding empty -> DONE.
- mem_rvalid is ignored outside READ, which drops stale returns after a reset mid-operation.
- Reset mid-transfer: immediate abort, no done pulse, FIFO contents discarded.
- s_in_valid/s_out_ready are don't-care outside their direction's state.

Decomposition:
- Shared package: typedef enum dram_port_state_e {DP_IDLE, DP_READ, DP_WRITE, DP_DONE}, alongside the existing ub_dma_state_e; ADDR_WIDTH/DATA_WIDTH constants stay there.
- Sub-module: stream_fifo, a parameterised synchronous FIFO (DEPTH, WIDTH) with push, pop, count, full, empty, head, first-word-fall-through, async reset. It is reusable by the DMA engine.

Test Plan:
- Read, dir=1, base=0x100, length=8, memory[a]=a^0xA5A5, rvalid latency 3, s_out_ready=1 -> 8 words 0x100^0xA5A5.. in order, mem_addr 0x100..0x107, one done pulse, busy low after.
- Read backpressure: length=16, s_out_ready=0 for 20 cycles, then 1 -> at most FIFO_DEPTH=4 grants before first pop, no overflow, all 16 words delivered in order.
- Write, dir=0, base=0x20, length=5, s_in_data 1..5, mem_gnt delayed 2 cycles per request -> writes (0x20,1)..(0x24,5), s_in_ready low while holding full, done once.
- length=0 with start -> no mem_req, done pulses 2 cycles after start; start asserted while busy -> ignored, counts unchanged.
- Address wrap: ADDR_W=8, base=0xFE, length=4 read -> mem_addr FE, FF, 00, 01.
- Reset asserted mid-read with 2 outstanding; late mem_rvalid after release -> all outputs 0, state IDLE, no s_out_valid, no done.

Source files
------------

// File: rtl/dram_stream_port_pkg.sv
// dram_stream_port_pkg: shared widths and state encodings for the DMA streaming slice
package dram_stream_port_pkg;
   localparam int ADDR_WIDTH = 16;
   localparam int DATA_WIDTH = 16;
   typedef enum logic [2:0] {UB_IDLE, UB_RD_REQ, UB_RD_DATA, UB_WR_REQ, UB_WR_DATA, UB_DONE} ub_dma_state_e;
   typedef enum logic [1:0] {DP_IDLE, DP_READ, DP_WRITE, DP_DONE} dram_port_state_e;
endpackage

// File: rtl/dram_stream_port_if.sv
// dram_stream_port_if: control, stream and memory request/grant bundle of the DRAM stream port
interface dram_stream_port_if
   import dram_stream_port_pkg::*;
#(
   parameter int ADDR_W = ADDR_WIDTH,
   parameter int DATA_W = DATA_WIDTH
);
   logic              start;
   logic              dir;
   logic [ADDR_W-1:0] dram_base_addr;
   logic [15:0]       length;
   logic              busy;
   logic              done;
   logic              s_out_valid;
   logic              s_out_ready;
   logic [DATA_W-1:0] s_out_data;
   logic              s_in_valid;
   logic              s_in_ready;
   logic [DATA_W-1:0] s_in_data;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_gnt;
   logic              mem_rvalid;
   logic [DATA_W-1:0] mem_rdata;
   modport slave (
      input  start, dir, dram_base_addr, length, s_out_ready, s_in_valid, s_in_data,
             mem_gnt, mem_rvalid, mem_rdata,
      output busy, done, s_out_valid, s_out_data, s_in_ready, mem_req, mem_we, mem_addr, mem_wdata
   );
   modport master (
      output start, dir, dram_base_addr, length, s_out_ready, s_in_valid, s_in_data,
             mem_gnt, mem_rvalid, mem_rdata,
      input  busy, done, s_out_valid, s_out_data, s_in_ready, mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/dram_stream_port_stream_fifo.sv
// stream_fifo: first-word-fall-through synchronous FIFO; a push while full is accepted only alongside a pop
module stream_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic             do_push, do_pop;
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];
   assign full    = count == (AW+1)'(DEPTH);
   assign empty   = count == '0;
   // storage and pointers; power-of-two depth lets the pointers wrap on their own
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) mem[wr_ptr] <= din;
         wr_ptr <= wr_ptr + AW'(do_push);
         rd_ptr <= rd_ptr + AW'(do_pop);
         count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
endmodule

// File: rtl/dram_stream_port.sv
// dram_stream_port: DRAM-side responder that sources read streams and sinks write streams for the UB DMA engine
module dram_stream_port
   import dram_stream_port_pkg::*;
#(
   parameter int ADDR_W     = ADDR_WIDTH,
   parameter int DATA_W     = DATA_WIDTH,
   parameter int FIFO_DEPTH = 4
) (
   input logic         clk,
   input logic         reset,
   dram_stream_port_if.slave bus
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   dram_port_state_e  state;
   logic [ADDR_W-1:0] base, mem_addr;
   logic [15:0]       len, issued, outstanding, delivered, issued_n, outst_n, deliv_n;
   logic [DATA_W-1:0] mem_wdata, head;
   logic [CW-1:0]     fifo_count;
   logic              busy, done, mem_req, mem_we, s_in_ready, full, empty;
   logic              gnt, rv, pop, acc, credit;

   stream_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_fifo (
      .clk(clk), .reset(reset), .push(rv), .pop(pop), .din(bus.mem_rdata),
      .head(head), .count(fifo_count), .full(full), .empty(empty)
   );

   assign bus.busy        = busy;
   assign bus.done        = done;
   assign bus.s_out_valid = !empty;
   assign bus.s_out_data  = head;
   assign bus.s_in_ready  = s_in_ready;
   assign bus.mem_req     = mem_req;
   assign bus.mem_we      = mem_we;
   assign bus.mem_addr    = mem_addr;
   assign bus.mem_wdata   = mem_wdata;

   // handshakes of this cycle and the counter values they produce; credit looks at next-cycle occupancy
   always_comb begin
      gnt      = mem_req && bus.mem_gnt;
      rv       = state == DP_READ && bus.mem_rvalid;
      pop      = state == DP_READ && !empty && bus.s_out_ready;
      acc      = state == DP_WRITE && s_in_ready && bus.s_in_valid;
      issued_n = issued + 16'(gnt);
      outst_n  = outstanding + 16'(gnt) - 16'(rv);
      deliv_n  = delivered + 16'(pop || acc);
      credit   = outst_n + 16'(fifo_count) + 16'(rv) - 16'(pop) < 16'(FIFO_DEPTH);
   end

   // transfer FSM with registered outputs; in WRITE, mem_req doubles as the holding-full flag and mem_wdata as the holding register
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state       <= DP_IDLE;
         base        <= '0;
         len         <= '0;
         issued      <= '0;
         outstanding <= '0;
         delivered   <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         s_in_ready  <= 1'b0;
      end else begin
         assert (!(rv && full && !pop));
         case (state)
            DP_IDLE:
               if (bus.start) begin
                  base        <= bus.dram_base_addr;
                  len         <= bus.length;
                  issued      <= '0;
                  outstanding <= '0;
                  delivered   <= '0;
                  busy        <= 1'b1;
                  done        <= bus.length == '0;
                  state       <= bus.length == '0 ? DP_DONE : bus.dir ? DP_READ : DP_WRITE;
                  mem_req     <= bus.dir && bus.length != '0;
                  mem_we      <= 1'b0;
                  mem_addr    <= bus.dram_base_addr;
                  s_in_ready  <= !bus.dir && bus.length != '0;
               end
            DP_READ: begin
               issued      <= issued_n;
               outstanding <= outst_n;
               delivered   <= deliv_n;
               mem_req     <= issued_n < len && credit;
               mem_addr    <= base + ADDR_W'(issued_n);
               if (delivered == len) begin
                  state <= DP_DONE;
                  done  <= 1'b1;
               end
            end
            DP_WRITE: begin
               issued     <= issued_n;
               delivered  <= deliv_n;
               mem_addr   <= base + ADDR_W'(issued_n);
               s_in_ready <= !(acc || (mem_req && !gnt)) && deliv_n < len;
               if (acc) begin
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b1;
                  mem_wdata <= bus.s_in_data;
               end else if (gnt) begin
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
               end
               if (issued == len && !mem_req) begin
                  state <= DP_DONE;
                  done  <= 1'b1;
               end
            end
            DP_DONE: begin
               state <= DP_IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
endmodule
